// File: rtl/hdmi_to_blocks.sv
// Raster-to-block converter: collects 8-line strips of an HDMI pixel stream in a
// ping-pong strip buffer and replays each finished strip as 8x8 blocks.
module hdmi_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hdmi_v_sync,
  input  logic                     hdmi_h_sync,
  input  logic                     hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                     blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                     blk_sob,
  output logic                     blk_eob,
  output logic                     blk_sof,
  output logic                     err_ovf,
  output logic                     err_line
);
  localparam int COLS   = X_RES / N;
  localparam int WORDS  = COLS * 8;
  localparam int EPB    = 8 / N;
  localparam int BLKS   = X_RES / 8;
  localparam int STRIPS = Y_RES / 8;
  localparam int PW     = 24 * N;
  localparam int AW     = $clog2(WORDS);
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BW     = (BLKS > 1) ? $clog2(BLKS) : 1;
  localparam int EW     = (EPB > 1) ? $clog2(EPB) : 1;
  localparam int SW     = (STRIPS > 1) ? $clog2(STRIPS) : 1;

  typedef enum logic [1:0] {WAIT_FRAME, ARMED, ACTIVE, DONE} wstate_t;
  typedef enum logic {R_IDLE, R_READ} rstate_t;

  wstate_t         wstate, wstate_nxt;
  rstate_t         rstate, rstate_nxt;
  logic            v_prev, h_prev, v_rise, h_rise;
  logic [CW-1:0]   col;
  logic [2:0]      row;
  logic [SW-1:0]   strip;
  logic            wsel;
  logic            wr_en, col_wrap, strip_done, cnt_clear, line_err;
  logic [AW-1:0]   waddr;
  logic [BW-1:0]   blk;
  logic [2:0]      line;
  logic [EW-1:0]   elem;
  logic            rsel, pend, pend_sel;
  logic [SW-1:0]   rstrip, pend_strip;
  logic            rd_en, last_addr, load_new, load_pend, queue_new;
  logic [AW-1:0]   raddr_p0;
  logic [PW-1:0]   mem [2][WORDS];
  logic [PW-1:0]   rdata_p1;
  logic            vld_p1, sob_p1, eob_p1, sof_p1;

  assign v_rise = hdmi_v_sync & ~v_prev;
  assign h_rise = hdmi_h_sync & ~h_prev;
  assign waddr  = AW'(int'(row) * COLS + int'(col));

  always_comb begin
    wstate_nxt = wstate;
    wr_en      = 1'b0;
    col_wrap   = 1'b0;
    strip_done = 1'b0;
    cnt_clear  = 1'b0;
    line_err   = 1'b0;
    case (wstate)
      WAIT_FRAME: if (hdmi_v_sync) wstate_nxt = ARMED;
      ARMED: begin
        cnt_clear = 1'b1;
        if (!hdmi_v_sync) wstate_nxt = ACTIVE;
      end
      ACTIVE: begin
        // a new frame abandons any partial strip; it is never read out
        if (v_rise) begin
          wstate_nxt = ARMED;
          cnt_clear  = 1'b1;
        end else if (h_rise && col != '0) begin
          line_err = 1'b1;
        end else if (hdmi_data_valid) begin
          wr_en = 1'b1;
          if (col == CW'(COLS - 1)) begin
            col_wrap = 1'b1;
            if (row == 3'd7) begin
              strip_done = 1'b1;
              if (strip == SW'(STRIPS - 1)) wstate_nxt = DONE;
            end
          end
        end
      end
      DONE: if (v_rise) wstate_nxt = ARMED;
      default: wstate_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate   <= WAIT_FRAME;
      v_prev   <= 1'b0;
      h_prev   <= 1'b0;
      col      <= '0;
      row      <= '0;
      strip    <= '0;
      wsel     <= 1'b0;
      err_line <= 1'b0;
    end else begin
      wstate   <= wstate_nxt;
      v_prev   <= hdmi_v_sync;
      h_prev   <= hdmi_h_sync;
      err_line <= err_line | line_err;
      if (cnt_clear) begin
        col   <= '0;
        row   <= '0;
        strip <= '0;
      end else if (line_err) begin
        col <= '0;
      end else if (wr_en) begin
        if (col_wrap) begin
          col <= '0;
          row <= row + 3'd1;
          if (row == 3'd7) begin
            wsel  <= ~wsel;
            strip <= (strip == SW'(STRIPS - 1)) ? '0 : strip + SW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign last_addr = (blk == BW'(BLKS - 1)) && (line == 3'd7) && (elem == EW'(EPB - 1));

  always_comb begin
    rstate_nxt = rstate;
    rd_en      = 1'b0;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    queue_new  = 1'b0;
    case (rstate)
      R_IDLE: if (strip_done) begin
        rstate_nxt = R_READ;
        load_new   = 1'b1;
      end
      R_READ: begin
        rd_en = 1'b1;
        // a strip finishing on the final address chains straight on, no idle beat
        if (last_addr) begin
          if (pend) begin
            load_pend = 1'b1;
            queue_new = strip_done;
          end else if (strip_done) begin
            load_new = 1'b1;
          end else begin
            rstate_nxt = R_IDLE;
          end
        end else begin
          queue_new = strip_done;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate     <= R_IDLE;
      blk        <= '0;
      line       <= '0;
      elem       <= '0;
      rsel       <= 1'b0;
      rstrip     <= '0;
      pend       <= 1'b0;
      pend_sel   <= 1'b0;
      pend_strip <= '0;
      err_ovf    <= 1'b0;
    end else begin
      rstate  <= rstate_nxt;
      err_ovf <= err_ovf | ((rstate == R_READ) && strip_done);
      if (load_new) begin
        rsel   <= wsel;
        rstrip <= strip;
      end else if (load_pend) begin
        rsel   <= pend_sel;
        rstrip <= pend_strip;
      end
      if (queue_new) begin
        pend       <= 1'b1;
        pend_sel   <= wsel;
        pend_strip <= strip;
      end else if (load_pend) begin
        pend <= 1'b0;
      end
      if (load_new || load_pend) begin
        blk  <= '0;
        line <= '0;
        elem <= '0;
      end else if (rd_en) begin
        if (elem == EW'(EPB - 1)) begin
          elem <= '0;
          if (line == 3'd7) begin
            line <= '0;
            blk  <= blk + BW'(1);
          end else begin
            line <= line + 3'd1;
          end
        end else begin
          elem <= elem + EW'(1);
        end
      end
    end
  end

  // stage p0: read address and beat flags from the reader counters
  assign raddr_p0 = AW'(int'(line) * COLS + int'(blk) * EPB + int'(elem));

  // stage p1: strip buffer read data
  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel][waddr] <= {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
    rdata_p1 <= mem[rsel][raddr_p0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sob_p1 <= 1'b0;
      eob_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      sob_p1 <= rd_en && line == 3'd0 && elem == '0;
      eob_p1 <= rd_en && line == 3'd7 && elem == EW'(EPB - 1);
      sof_p1 <= rd_en && rstrip == '0 && blk == '0 && line == 3'd0 && elem == '0;
    end
  end

  // stage p2: registered block outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid   <= 1'b0;
      blk_sob     <= 1'b0;
      blk_eob     <= 1'b0;
      blk_sof     <= 1'b0;
      blk_data_y  <= '0;
      blk_data_cr <= '0;
      blk_data_cb <= '0;
    end else begin
      blk_valid   <= vld_p1;
      blk_sob     <= sob_p1;
      blk_eob     <= eob_p1;
      blk_sof     <= sof_p1;
      blk_data_y  <= rdata_p1[8*N-1:0];
      blk_data_cr <= rdata_p1[16*N-1:8*N];
      blk_data_cb <= rdata_p1[24*N-1:16*N];
    end
  end
endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Bench for hdmi_to_blocks: drives small frames and compares the block stream
// against blocks cut from a reference image held in the bench.
`timescale 1ns/1ps
module tb_hdmi_to_blocks;
  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int Y_RES = 24;
  localparam int COLS  = X_RES / N;
  localparam int BLKS  = X_RES / 8;
  localparam int BPB   = 64 / N;
  localparam int BPS   = X_RES * 8 / N;
  localparam int SPF   = Y_RES / 8;

  typedef struct packed {
    logic [8*N-1:0] y;
    logic [8*N-1:0] cr;
    logic [8*N-1:0] cb;
    logic           sob;
    logic           eob;
    logic           sof;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hdmi_v_sync, hdmi_h_sync, hdmi_data_valid;
  logic signed [N-1:0][7:0] hdmi_data_y, hdmi_data_cr, hdmi_data_cb;
  logic blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  beat_t exp_q[$];
  beat_t cap_q[$];
  int    cap_cyc[$];
  logic [7:0] img_y [Y_RES][X_RES];
  logic [7:0] img_cr[Y_RES][X_RES];
  logic [7:0] img_cb[Y_RES][X_RES];

  hdmi_to_blocks #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdmi_v_sync(hdmi_v_sync), .hdmi_h_sync(hdmi_h_sync), .hdmi_data_valid(hdmi_data_valid),
    .hdmi_data_y(hdmi_data_y), .hdmi_data_cr(hdmi_data_cr), .hdmi_data_cb(hdmi_data_cb),
    .blk_valid(blk_valid), .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr),
    .blk_data_cb(blk_data_cb), .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
    .err_ovf(err_ovf), .err_line(err_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (rst_n && blk_valid) begin
      b.y = blk_data_y; b.cr = blk_data_cr; b.cb = blk_data_cb;
      b.sob = blk_sob; b.eob = blk_eob; b.sof = blk_sof;
      cap_q.push_back(b);
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats captured", cap_q.size());
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit vld, input bit vs, input bit hs,
                       input logic [8*N-1:0] y, input logic [8*N-1:0] cr, input logic [8*N-1:0] cb);
    @(posedge clk); #1;
    hdmi_data_valid = vld; hdmi_v_sync = vs; hdmi_h_sync = hs;
    hdmi_data_y = y; hdmi_data_cr = cr; hdmi_data_cb = cb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic vsync();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
    idle(2);
  endtask

  task automatic hpulse();
    idle(1);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    idle(1);
  endtask

  task automatic send_line(input int ln, input bit blank);
    logic [8*N-1:0] y, cr, cb;
    for (int c = 0; c < COLS; c++) begin
      for (int j = 0; j < N; j++) begin
        y[j*8 +: 8]  = img_y[ln][c*N+j];
        cr[j*8 +: 8] = img_cr[ln][c*N+j];
        cb[j*8 +: 8] = img_cb[ln][c*N+j];
      end
      drive(1'b1, 1'b0, 1'b0, y, cr, cb);
    end
    last_wr_cyc = cyc;
    if (blank) hpulse();
  endtask

  task automatic fill_frame(input bit pattern);
    for (int ln = 0; ln < Y_RES; ln++)
      for (int x = 0; x < X_RES; x++) begin
        img_y[ln][x]  = pattern ? 8'(8 * ln + x) : 8'($urandom);
        img_cr[ln][x] = 8'($urandom);
        img_cb[ln][x] = 8'($urandom);
      end
  endtask

  // a block is 64 pixels in raster order; beat k carries pixels k*N .. k*N+N-1
  task automatic build_strip(input int s);
    beat_t e;
    for (int b = 0; b < BLKS; b++)
      for (int k = 0; k < BPB; k++) begin
        for (int j = 0; j < N; j++) begin
          int p, ln, x;
          p  = k * N + j;
          ln = s * 8 + p / 8;
          x  = b * 8 + p % 8;
          e.y[j*8 +: 8]  = img_y[ln][x];
          e.cr[j*8 +: 8] = img_cr[ln][x];
          e.cb[j*8 +: 8] = img_cb[ln][x];
        end
        e.sob = (k == 0);
        e.eob = (k == BPB - 1);
        e.sof = (s == 0) && (b == 0) && (k == 0);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_drain(input int n);
    int t;
    t = 0;
    while (cap_q.size() < n && t < 800) begin
      @(posedge clk);
      t++;
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic clear_queues();
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_reset();
    int t;
    #3;
    tests++;
    if ({blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b required 000000",
                        {blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line});
    end
    tests++;
    if ({blk_data_y, blk_data_cr, blk_data_cb} !== '0) begin
      fails++; $display("FAIL reset_data: got %h required 0", {blk_data_y, blk_data_cr, blk_data_cb});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    fill_frame(1'b0);
    vsync();
    for (int ln = 0; ln < 8; ln++) send_line(ln, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (!blk_valid && t < 50);
    tests++;
    if (blk_valid !== 1'b1) begin
      fails++; $display("FAIL reset_inflight: blk_valid got %b required 1", blk_valid);
    end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line, blk_data_y, blk_data_cr, blk_data_cb} !== '0) begin
      fails++; $display("FAIL reset_midstrip: outputs got %h required 0",
                        {blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line, blk_data_y, blk_data_cr, blk_data_cb});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_queues();
    for (int ln = 0; ln < 8; ln++) send_line(ln, 1'b1);
    idle(80);
    tests++;
    if (cap_q.size() !== 0) begin
      fails++; $display("FAIL reset_no_vsync: got %0d beats required 0", cap_q.size());
    end
  endtask

  task automatic test_frame();
    int lw0, nsof;
    clear_queues();
    fill_frame(1'b1);
    for (int s = 0; s < SPF; s++) build_strip(s);
    vsync();
    lw0 = 0;
    for (int ln = 0; ln < Y_RES; ln++) begin
      send_line(ln, 1'b1);
      if (ln == 7) lw0 = last_wr_cyc;
    end
    wait_drain(BPS * SPF);
    tests++;
    if (cap_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL frame_count: got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      tests++;
      if (cap_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL frame_beat%0d: got %h required %h", k, cap_q[k], exp_q[k]);
      end
    end
    if (cap_q.size() == BPS * SPF) begin
      tests++;
      if (cap_q[0].y !== 16'h0100) begin
        fails++; $display("FAIL frame_beat0_y: got %h required 0100", cap_q[0].y);
      end
      tests++;
      if (cap_q[4].y !== 16'h0908) begin
        fails++; $display("FAIL frame_beat4_y: got %h required 0908", cap_q[4].y);
      end
      tests++;
      if (cap_cyc[0] !== lw0 + 3) begin
        fails++; $display("FAIL latency_first: got cycle %0d required %0d", cap_cyc[0], lw0 + 3);
      end
      tests++;
      if (cap_cyc[BPS-1] !== lw0 + 3 + BPS - 1) begin
        fails++; $display("FAIL latency_last: got cycle %0d required %0d", cap_cyc[BPS-1], lw0 + 3 + BPS - 1);
      end
      for (int s = 0; s < SPF; s++) begin
        tests++;
        if (cap_cyc[s*BPS + BPS - 1] - cap_cyc[s*BPS] !== BPS - 1) begin
          fails++; $display("FAIL strip%0d_gapless: span got %0d required %0d",
                            s, cap_cyc[s*BPS + BPS - 1] - cap_cyc[s*BPS], BPS - 1);
        end
      end
      nsof = 0;
      foreach (cap_q[k]) if (cap_q[k].sof) nsof++;
      tests++;
      if (nsof !== 1) begin
        fails++; $display("FAIL frame_sof_count: got %0d required 1", nsof);
      end
    end
    tests++;
    if ({err_ovf, err_line} !== 2'b00) begin
      fails++; $display("FAIL frame_errors: got %b required 00", {err_ovf, err_line});
    end
  endtask

  task automatic test_overflow();
    clear_queues();
    fill_frame(1'b0);
    for (int s = 0; s < SPF; s++) build_strip(s);
    vsync();
    for (int ln = 0; ln < 7; ln++) send_line(ln, 1'b1);
    for (int ln = 7; ln < Y_RES; ln++) send_line(ln, 1'b0);
    idle(1);
    wait_drain(BPS * SPF);
    tests++;
    if (cap_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL ovf_count: got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      tests++;
      if (cap_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL ovf_beat%0d: got %h required %h", k, cap_q[k], exp_q[k]);
      end
    end
    tests++;
    if (err_ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_flag: got %b required 1", err_ovf);
    end
    tests++;
    if (err_line !== 1'b0) begin
      fails++; $display("FAIL ovf_line_flag: got %b required 0", err_line);
    end
  endtask

  task automatic test_line_err();
    clear_queues();
    fill_frame(1'b0);
    for (int s = 0; s < SPF; s++) build_strip(s);
    tests++;
    if (err_line !== 1'b0) begin
      fails++; $display("FAIL line_err_before: got %b required 0", err_line);
    end
    vsync();
    send_line(0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    hpulse();
    for (int ln = 1; ln < Y_RES; ln++) send_line(ln, 1'b1);
    wait_drain(BPS * SPF);
    tests++;
    if (err_line !== 1'b1) begin
      fails++; $display("FAIL line_err_flag: got %b required 1", err_line);
    end
    tests++;
    if (cap_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL line_err_count: got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      tests++;
      if (cap_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL line_err_beat%0d: got %h required %h", k, cap_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_vsync_abort();
    clear_queues();
    fill_frame(1'b0);
    build_strip(0);
    vsync();
    for (int ln = 0; ln < 13; ln++) send_line(ln, 1'b1);
    fill_frame(1'b0);
    for (int s = 0; s < SPF; s++) build_strip(s);
    vsync();
    for (int ln = 0; ln < Y_RES; ln++) send_line(ln, 1'b1);
    wait_drain(BPS * (SPF + 1));
    tests++;
    if (cap_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL abort_count: got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      tests++;
      if (cap_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL abort_beat%0d: got %h required %h", k, cap_q[k], exp_q[k]);
      end
    end
    if (cap_q.size() > BPS) begin
      tests++;
      if (cap_q[BPS].sof !== 1'b1) begin
        fails++; $display("FAIL abort_new_frame_sof: got %b required 1", cap_q[BPS].sof);
      end
    end
  endtask

  initial begin
    hdmi_v_sync = 1'b0; hdmi_h_sync = 1'b0; hdmi_data_valid = 1'b0;
    hdmi_data_y = '0; hdmi_data_cr = '0; hdmi_data_cb = '0;
    test_reset();
    test_frame();
    test_overflow();
    test_line_err();
    test_vsync_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
